uart_flash_loader: RTL and testbench
====================================

Name: uart_flash_loader

Overview:
- Programming-mode controller between the board UART pin and the instruction memory write port.
- When `flash` is raised, it holds the RISC-V core in reset and receives a length-prefixed program image over `uart_serial`.
- It writes the image word-by-word into instruction memory, then releases the core.
- Contains its own 8N1 UART receiver and the load-sequencing FSM.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200); minimum 4.
- ADDR_W, 12: width of imem byte address.
- MAX_WORDS, 1024: capacity check; larger images abort with error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- flash  in  1  programming request, level, asynchronous to clk.
- uart_serial  in  1  UART RX line, idle high, asynchronous to clk.
- core_hold  out  1  keeps the CPU in reset while high.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  byte address, always word-aligned.
- imem_wdata  out  32  word to write.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag, cleared at the next load start.

Behaviour:
- Reset (rst=0, any time, including mid-load):
  - All outputs 0.
  - FSM to IDLE; RX to idle.
  - Word counter and byte assembler cleared.
- Synchronisers:
  - `flash` and `uart_serial` each pass through a 2-flop synchroniser; flop reset values are 0 for `flash` and 1 for `uart_serial`.
  - The load start event is the rising edge of synchronised `flash`.
- UART RX:
  - Start detect on synchronised line low while idle.
  - Re-sample at CLKS_PER_BIT/2; if high, treat as a glitch and return to idle.
  - Then sample 8 data bits, LSB first, each CLKS_PER_BIT apart, then the stop bit.
  - Stop bit = 1: issue an internal byte_valid pulse for one cycle.
  - Stop bit = 0: issue a frame_err pulse; no byte is delivered.
  - RX runs regardless of FSM state; bytes arriving outside LEN/DATA states are ignored.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
  - IDLE: core_hold=0, busy=0. On flash rise: err←0, word_idx←0 → LEN_LO.
  - LEN_LO: on byte → len[7:0] → LEN_HI.
  - LEN_HI: on byte → len[15:8].
    - len=0 → DONE.
    - len>MAX_WORDS → ERR.
    - otherwise → DATA with byte_cnt=0.
  - DATA: each byte shifts into the word little-endian (first byte = bits 7:0). After the 4th byte → WRITE.
  - WRITE: exactly one cycle. imem_we=1, imem_addr=word_idx<<2 (truncated to ADDR_W), imem_wdata=assembled word. Then word_idx+1.
    - If word_idx+1 == len → DONE.
    - Otherwise → DATA.
  - DONE: done=1 for one cycle → IDLE. core_hold falls on the cycle IDLE is entered.
  - ERR: err←1 → IDLE, core_hold released. err stays set until the next flash rise.
- core_hold and busy are 1 in every state except IDLE. They are registered outputs.
- Latency: imem_we asserts 1 cycle after the byte_valid of the 4th byte. done asserts 1 cycle after the last WRITE.
- Abort conditions, from LEN_LO, LEN_HI, DATA or WRITE:
  - frame_err → ERR.
  - synchronised flash low → ERR.
  - Partially assembled words are never written.
- Simultaneous events:
  - frame_err has priority over byte_valid (they are mutually exclusive by construction).
  - Flash fall in the same cycle as a WRITE: the write completes, then the FSM goes to ERR.
- A flash rise while not in IDLE is ignored. A new load requires flash low, then high again, after returning to IDLE.
- imem_addr/imem_wdata hold their last values when imem_we=0.

Test Plan:
- Reset: hold rst=0 with flash=1 and the line toggling → all outputs 0. Release rst while flash=1 → no load starts (no rising edge seen) until flash is cycled.
- Nominal load, CLKS_PER_BIT=4, bytes 02 00 13 05 A0 00 93 05 10 00:
  - imem_we pulses twice: addr 0x000 with data 0x00A00513, then addr 0x004 with data 0x00100593.
  - done pulses once; core_hold high from flash rise until the cycle after done.
- Zero-length image, bytes 00 00 → no imem_we, done pulse, core_hold drops.
- Framing error: send a byte with stop bit 0 during DATA → err=1, no write of the partial word, core_hold=0, FSM in IDLE. Next flash rise clears err.
- Oversize image, len 0x0401 with MAX_WORDS=1024 → ERR after the 2nd byte, no writes.
- Abort and glitch rejection:
  - Drop flash after 6 data bytes → exactly 1 write, err=1.
  - A start glitch shorter than CLKS_PER_BIT/2 → no byte is received.
  - Mid-load rst=0 → outputs clear immediately (asynchronously).

Source files
------------

// File: rtl/uart_flash_loader.sv
// rtl/uart_flash_loader.sv - UART program loader that streams a length-prefixed image into imem
// Holds the core in reset while a load is in progress; contains the 8N1 receiver and load FSM.
module uart_flash_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 12,
  parameter int MAX_WORDS    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flash,
  input  logic              uart_serial,
  output logic              core_hold,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic       flash_s1, flash_s2, flash_d, armed;
  logic [1:0] settle;
  logic       rx_s1, rx_s2;
  logic       flash_rise, abort;

  // A load only starts after flash has been seen low post-reset, so a level already high at reset is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flash_s1 <= 1'b0;
      flash_s2 <= 1'b0;
      flash_d  <= 1'b0;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      settle   <= 2'd0;
      armed    <= 1'b0;
    end else begin
      flash_s1 <= flash;
      flash_s2 <= flash_s1;
      flash_d  <= flash_s2;
      rx_s1    <= uart_serial;
      rx_s2    <= rx_s1;
      if (settle != 2'd2) settle <= settle + 2'd1;
      else if (!flash_s2) armed <= 1'b1;
    end
  end

  assign flash_rise = armed & flash_s2 & ~flash_d;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  rx_state_t       rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            byte_valid, frame_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= 3'd0;
      rx_shift   <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else rx_bit <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_s2) begin
              byte_valid <= 1'b1;
              rx_state   <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              rx_state  <= RX_WAIT;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        // A bad stop bit leaves the line low; wait for idle so it is not taken as a new start.
        RX_WAIT: if (rx_s2) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR} state_t;
  state_t      state;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [31:0] wbuf;

  assign abort = frame_err | ~flash_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      len        <= 16'd0;
      word_idx   <= 16'd0;
      byte_cnt   <= 2'd0;
      wbuf       <= 32'd0;
      core_hold  <= 1'b0;
      busy       <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flash_rise) begin
            err       <= 1'b0;
            word_idx  <= 16'd0;
            byte_cnt  <= 2'd0;
            core_hold <= 1'b1;
            busy      <= 1'b1;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (abort) state <= ERR;
          else if (byte_valid) begin
            len[7:0] <= rx_shift;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (abort) state <= ERR;
          else if (byte_valid) begin
            len[15:8] <= rx_shift;
            if ({rx_shift, len[7:0]} == 16'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end else if ({1'b0, rx_shift, len[7:0]} > 17'(MAX_WORDS)) begin
              state <= ERR;
            end else begin
              byte_cnt <= 2'd0;
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (abort) state <= ERR;
          else if (byte_valid) begin
            wbuf     <= {rx_shift, wbuf[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= ADDR_W'({word_idx, 2'b00});
              imem_wdata <= {rx_shift, wbuf[31:8]};
              state      <= WRITE;
            end
          end
        end
        WRITE: begin
          imem_we  <= 1'b0;
          word_idx <= word_idx + 16'd1;
          if (abort) state <= ERR;
          else if (word_idx + 16'd1 == len) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= DATA;
          end
        end
        DONE: begin
          done      <= 1'b0;
          core_hold <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        ERR: begin
          err       <= 1'b1;
          core_hold <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_flash_loader.sv
// tb/tb_uart_flash_loader.sv - directed bench for uart_flash_loader with a write scoreboard
module tb_uart_flash_loader;

  localparam int CPB = 4;

  logic        clk, rst, flash, line;
  logic        core_hold, imem_we, busy, done, err;
  logic [11:0] imem_addr;
  logic [31:0] imem_wdata;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic after_done = 1'b0;
  logic [43:0] exp_q[$];

  uart_flash_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(12), .MAX_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .flash(flash), .uart_serial(line),
    .core_hold(core_hold), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (after_done) begin
      check("hold_after_done", core_hold, 1'b0);
      check("busy_after_done", busy, 1'b0);
      after_done <= 1'b0;
    end
    if (imem_we) begin
      wr_cnt <= wr_cnt + 1;
      check("write_expected", exp_q.size() > 0, 1'b1);
      check("hold_at_write", core_hold, 1'b1);
      if (exp_q.size() > 0) begin
        logic [43:0] e;
        e = exp_q.pop_front();
        check("write_addr", imem_addr, e[43:32]);
        check("write_data", imem_wdata, e[31:0]);
      end
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      check("hold_at_done", core_hold, 1'b1);
      after_done <= 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (CPB) @(negedge clk);
    end
    line = stop;
    repeat (CPB) @(negedge clk);
    line = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_cnt >= target) break;
    end
    check("done_seen", done_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    rst = 1'b0; flash = 1'b1; line = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      line = ~line;
    end
    line = 1'b1;
    check("rst_core_hold", core_hold, 1'b0);
    check("rst_imem_we", imem_we, 1'b0);
    check("rst_imem_addr", imem_addr, 12'h000);
    check("rst_imem_wdata", imem_wdata, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);

    @(negedge clk); rst = 1'b1;
    repeat (20) @(negedge clk);
    check("no_start_after_rst", busy, 1'b0);
    flash = 1'b0;
    repeat (5) @(negedge clk);

    // nominal two-word image
    exp_q.push_back({12'h000, 32'h00A00513});
    exp_q.push_back({12'h004, 32'h00100593});
    flash = 1'b1;
    repeat (4) @(negedge clk);
    check("nom_hold", core_hold, 1'b1);
    check("nom_busy", busy, 1'b1);
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'hA0, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
    wait_done(1);
    repeat (3) @(negedge clk);
    check("nom_writes", wr_cnt, 2);
    check("nom_queue_empty", exp_q.size(), 0);
    check("nom_err", err, 1'b0);
    flash = 1'b0;
    repeat (5) @(negedge clk);

    // zero-length image
    flash = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    wait_done(2);
    repeat (3) @(negedge clk);
    check("zero_writes", wr_cnt, 2);
    check("zero_hold", core_hold, 1'b0);
    flash = 1'b0;
    repeat (5) @(negedge clk);

    // framing error inside a data word
    wr0 = wr_cnt;
    flash = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b0);
    repeat (6) @(negedge clk);
    check("ferr_err", err, 1'b1);
    check("ferr_hold", core_hold, 1'b0);
    check("ferr_busy", busy, 1'b0);
    check("ferr_writes", wr_cnt - wr0, 0);
    flash = 1'b0;
    repeat (5) @(negedge clk);
    flash = 1'b1;
    repeat (5) @(negedge clk);
    check("ferr_cleared", err, 1'b0);
    check("ferr_restart_busy", busy, 1'b1);
    flash = 1'b0;
    repeat (6) @(negedge clk);
    check("flash_drop_err", err, 1'b1);

    // oversize image
    wr0 = wr_cnt;
    flash = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'h01, 1'b1); send_byte(8'h04, 1'b1);
    repeat (4) @(negedge clk);
    check("big_err", err, 1'b1);
    check("big_busy", busy, 1'b0);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    check("big_writes", wr_cnt - wr0, 0);
    flash = 1'b0;
    repeat (5) @(negedge clk);

    // flash dropped after six data bytes
    wr0 = wr_cnt;
    exp_q.push_back({12'h000, 32'h44332211});
    flash = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'h04, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1); send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
    repeat (4) @(negedge clk);
    flash = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_writes", wr_cnt - wr0, 1);
    check("abort_queue_empty", exp_q.size(), 0);
    check("abort_err", err, 1'b1);
    check("abort_hold", core_hold, 1'b0);

    // start glitch shorter than half a bit
    flash = 1'b1;
    repeat (5) @(negedge clk);
    line = 1'b0;
    @(negedge clk);
    line = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    wait_done(3);
    repeat (3) @(negedge clk);
    check("glitch_err", err, 1'b0);
    check("glitch_busy", busy, 1'b0);
    flash = 1'b0;
    repeat (5) @(negedge clk);

    // asynchronous reset mid-load
    flash = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
    check("mid_busy_before", busy, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_hold", core_hold, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_wdata", imem_wdata, 32'h0);
    check("mid_rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_no_restart", busy, 1'b0);
    flash = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
